mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised memory access unit between the multicycle MIPS controller/datapath and a wait-state memory. Replaces the zero-latency combinational memory hookup with a registered request/ready handshake, byte/halfword/word sizing with byte enables, load sign extension, alignment checking and a bus timeout. Drives `Stall` back to the controller, which holds its memory state while `Stall`=1.

## Interface
- `DATA_W`, 32: data width in bits; multiple of 8, power of two, ≥16. Lanes `NB`=`DATA_W`/8, `OFF_W`=log2(`NB`).
- `ADDR_W`, 32: byte address width.
- `TIMEOUT`, 16: max cycles in BUSY waiting for `MemReady`; 0 disables the timeout.

Ports:
- `Clock`  in  1  system clock; all state on rising edge.
- `Resetn`  in  1  synchronous, active-low reset.
- `MemRead`  in  1  CPU read request (level, held until `Stall`=0).
- `MemWrite`  in  1  CPU write request (level, held until `Stall`=0).
- `Size`  in  2  00 byte, 01 halfword, 10 full word (`DATA_W`), 11 illegal.
- `LoadSigned`  in  1  1: sign-extend sub-word loads; 0: zero-extend.
- `Address`  in  `ADDR_W`  byte address.
- `WriteData`  in  `DATA_W`  store data, right-justified.
- `ReadData`  out  `DATA_W`  extended load result, valid in DONE.
- `Stall`  out  1  combinational: (`MemRead`|`MemWrite`) & state≠DONE.
- `Misaligned`  out  1  alignment/illegal-size fault, valid in DONE.
- `BusError`  out  1  timeout or read+write conflict, valid in DONE.
- `MemReq`  out  1  memory request, held high throughout BUSY.
- `MemWe`  out  1  1 write, 0 read.
- `MemAddr`  out  `ADDR_W`  word-aligned address (low `OFF_W` bits 0).
- `MemBe`  out  `NB`  byte enables, bit i = lane i (bits [8i+7:8i]).
- `MemWdata`  out  `DATA_W`  lane-positioned store data.
- `MemRdata`  in  `DATA_W`  memory read data, sampled when `MemReady`=1.
- `MemReady`  in  1  memory completion strobe.

## Operation
- FSM states IDLE, BUSY, DONE. Reset → IDLE; all registered outputs 0 (`ReadData`, `MemReq`, `MemWe`, `MemAddr`, `MemBe`, `MemWdata`, `Misaligned`, `BusError`); timeout counter 0.
- IDLE, no request: stay; `Misaligned`/`BusError` cleared.
- IDLE, `MemRead`&`MemWrite`: `BusError`←1, → DONE, no memory access.
- IDLE, single request, fault (`Size`=11; half with off[0]≠0; word with off≠0, off=`Address`[`OFF_W`-1:0]): `Misaligned`←1, → DONE, no memory access.
- IDLE, legal request: register `MemAddr`=`Address` with low `OFF_W` bits cleared, `MemWe`, `MemBe` (byte: 1<<off; half: 3<<off; word: all ones), `MemWdata` (byte/half data shifted to lane off; other lanes 0), `MemReq`←1, counter←0, → BUSY.
- BUSY: outputs stable. `MemReady`=1: capture lane(s) at off from `MemRdata`, extend per `LoadSigned` (writes: `ReadData`←0), `MemReq`←0, → DONE. Else counter++; if `TIMEOUT`≠0 and counter reaches `TIMEOUT`-1 without `MemReady`: `BusError`←1, `ReadData`←0, `MemReq`←0, → DONE.
- DONE: `Stall`=0 for exactly one cycle; flags and `ReadData` held; → IDLE unconditionally. A request still present in IDLE starts a new access.
- `MemReady` outside BUSY is ignored. Endianness little; word loads never extended.

## Timing
- Request seen at edge t (IDLE): `MemReq`=1 from t+1. `MemReady` at cycle t+1+k → DONE at t+2+k; `Stall` low in that cycle. Minimum 2 stall cycles (k=0).
- Fault paths: DONE at t+1, one stall cycle, `MemReq` never asserted.
- Timeout: `MemReq` high exactly `TIMEOUT` cycles, then DONE.
- `Resetn`=0 at any edge (incl. mid-BUSY): next cycle IDLE, `MemReq`=0, flags 0; pending access abandoned, no DONE.

## Test plan
- Word read 0x0000_0010, `MemReady` 3 cycles after `MemReq` rises, `MemRdata`=0xDEADBEEF → `MemBe`=1111, `ReadData`=0xDEADBEEF, `Stall` high 5 cycles.
- Signed byte load 0x0000_0013, `MemRdata`=0x80123456 → `MemBe`=1000, `ReadData`=0xFFFFFF80; same with `LoadSigned`=0 → 0x00000080.
- Half store 0x0000_0006, `WriteData`=0x0000BEEF → `MemAddr`=0x4, `MemBe`=1100, `MemWdata`=0xBEEF0000, `MemWe`=1.
- Word read at 0x0000_0002 and half at 0x0000_0001 → `Misaligned`=1 in DONE, `MemReq` never 1, one stall cycle.
- `TIMEOUT`=4, `MemReady` held 0 → `MemReq` high 4 cycles, `BusError`=1, `ReadData`=0; `MemRead`&`MemWrite` both 1 → `BusError`=1 with no `MemReq`.
- `Resetn` low for one cycle mid-BUSY → `MemReq`=0 next cycle, state IDLE, all flags 0; held request restarts normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Sits between the multicycle MIPS controller and a wait-state memory. A CPU
// request (held level on MemRead/MemWrite) is checked for size/alignment,
// turned into a registered MemReq/MemReady handshake with byte enables and
// lane-positioned store data, and completed in a one-cycle DONE state where
// Stall drops so the controller can advance. Loads are extracted from their
// byte lanes and sign- or zero-extended; a bus timeout guards against a
// memory that never answers.

module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            Size,
  input  logic                  LoadSigned,
  input  logic [ADDR_W-1:0]     Address,
  input  logic [DATA_W-1:0]     WriteData,
  output logic [DATA_W-1:0]     ReadData,
  output logic                  Stall,
  output logic                  Misaligned,
  output logic                  BusError,
  output logic                  MemReq,
  output logic                  MemWe,
  output logic [ADDR_W-1:0]     MemAddr,
  output logic [DATA_W/8-1:0]   MemBe,
  output logic [DATA_W-1:0]     MemWdata,
  input  logic [DATA_W-1:0]     MemRdata,
  input  logic                  MemReady
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Last counter value a BUSY cycle may reach before the access is abandoned.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_t;

  // Registered state
  state_t              r_state;
  logic [DATA_W-1:0]   r_read_data;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [NB-1:0]       r_mem_be;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_misaligned;
  logic                r_bus_error;
  logic [CNT_W-1:0]    r_cnt;
  logic [OFF_W-1:0]    r_off;
  size_t               r_size;
  logic                r_signed;

  // Next-state values
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   w_read_data_nxt;
  logic                w_mem_req_nxt;
  logic                w_mem_we_nxt;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic [NB-1:0]       w_mem_be_nxt;
  logic [DATA_W-1:0]   w_mem_wdata_nxt;
  logic                w_misaligned_nxt;
  logic                w_bus_error_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [OFF_W-1:0]    w_off_nxt;
  size_t               w_size_nxt;
  logic                w_signed_nxt;

  // Request decode
  logic                w_req;
  logic [OFF_W-1:0]    w_off;
  size_t               w_size;
  logic                w_fault;
  logic [NB-1:0]       w_be_start;
  logic [DATA_W-1:0]   w_wdata_start;

  // Load extraction
  logic [DATA_W-1:0]   w_rdata_shifted;
  logic [DATA_W-1:0]   w_lane_mask;
  logic                w_lane_sign;
  logic [DATA_W-1:0]   w_load_ext;

  assign w_req  = MemRead | MemWrite;
  assign w_off  = Address[OFF_W-1:0];
  assign w_size = size_t'(Size);

  // A halfword must sit on an even byte, a full word on a word boundary.
  assign w_fault = (w_size == SZ_ILLEGAL) ||
                   ((w_size == SZ_HALF) && w_off[0]) ||
                   ((w_size == SZ_WORD) && (w_off != '0));

  // Byte enables and lane-positioned store data for the incoming request.
  always_comb begin
    // NOTE: every signal driven here gets a value before any branch, so no path leaves one unassigned and no latch is inferred.
    w_be_start    = '1;
    w_wdata_start = WriteData;
    unique case (w_size)
      SZ_BYTE: begin
        w_be_start    = NB'(1) << w_off;
        w_wdata_start = DATA_W'(WriteData[7:0]) << {w_off, 3'b000};
      end
      SZ_HALF: begin
        w_be_start    = NB'(3) << w_off;
        w_wdata_start = DATA_W'(WriteData[15:0]) << {w_off, 3'b000};
      end
      default: begin
        w_be_start    = '1;
        w_wdata_start = WriteData;
      end
    endcase
  end

  // Bring the addressed lane(s) down to bit 0, then zero- or sign-extend.
  assign w_rdata_shifted = MemRdata >> {r_off, 3'b000};

  // Width mask and sign bit of the captured load; full words pass untouched.
  always_comb begin
    w_lane_mask = '1;
    w_lane_sign = 1'b0;
    unique case (r_size)
      SZ_BYTE: begin
        w_lane_mask = DATA_W'(8'hFF);
        w_lane_sign = w_rdata_shifted[7];
      end
      SZ_HALF: begin
        w_lane_mask = DATA_W'(16'hFFFF);
        w_lane_sign = w_rdata_shifted[15];
      end
      default: begin
        w_lane_mask = '1;
        w_lane_sign = 1'b0;
      end
    endcase
  end

  assign w_load_ext = (w_rdata_shifted & w_lane_mask) |
                      ((r_signed && w_lane_sign) ? ~w_lane_mask : '0);

  // Next-state and next-output logic of the IDLE/BUSY/DONE controller.
  always_comb begin
    w_state_nxt      = r_state;
    w_read_data_nxt  = r_read_data;
    w_mem_req_nxt    = r_mem_req;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_be_nxt     = r_mem_be;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_misaligned_nxt = r_misaligned;
    w_bus_error_nxt  = r_bus_error;
    w_cnt_nxt        = r_cnt;
    w_off_nxt        = r_off;
    w_size_nxt       = r_size;
    w_signed_nxt     = r_signed;

    unique case (r_state)
      ST_IDLE: begin
        w_misaligned_nxt = 1'b0;
        w_bus_error_nxt  = 1'b0;
        if (MemRead && MemWrite) begin
          // Conflicting request: report it without touching memory.
          w_bus_error_nxt = 1'b1;
          w_state_nxt     = ST_DONE;
        end else if (w_req) begin
          if (w_fault) begin
            w_misaligned_nxt = 1'b1;
            w_state_nxt      = ST_DONE;
          end else begin
            w_mem_addr_nxt  = {Address[ADDR_W-1:OFF_W], OFF_W'(0)};
            w_mem_we_nxt    = MemWrite;
            w_mem_be_nxt    = w_be_start;
            w_mem_wdata_nxt = w_wdata_start;
            w_mem_req_nxt   = 1'b1;
            w_cnt_nxt       = '0;
            w_off_nxt       = w_off;
            w_size_nxt      = w_size;
            w_signed_nxt    = LoadSigned;
            w_state_nxt     = ST_BUSY;
          end
        end
      end

      ST_BUSY: begin
        if (MemReady) begin
          w_read_data_nxt = r_mem_we ? '0 : w_load_ext;
          w_mem_req_nxt   = 1'b0;
          w_state_nxt     = ST_DONE;
        end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
          w_bus_error_nxt = 1'b1;
          w_read_data_nxt = '0;
          w_mem_req_nxt   = 1'b0;
          w_state_nxt     = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      // NOTE: non-blocking assignments here so every register samples the pre-edge values, independent of statement order.
      r_state      <= ST_IDLE;
      r_read_data  <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_be     <= '0;
      r_mem_wdata  <= '0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      r_cnt        <= '0;
      r_off        <= '0;
      r_size       <= SZ_BYTE;
      r_signed     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_read_data  <= w_read_data_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_be     <= w_mem_be_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_misaligned <= w_misaligned_nxt;
      r_bus_error  <= w_bus_error_nxt;
      r_cnt        <= w_cnt_nxt;
      r_off        <= w_off_nxt;
      r_size       <= w_size_nxt;
      r_signed     <= w_signed_nxt;
    end
  end

  // The controller is released only in DONE, and only if it is asking for memory.
  assign Stall      = w_req && (r_state != ST_DONE);
  assign ReadData   = r_read_data;
  assign Misaligned = r_misaligned;
  assign BusError   = r_bus_error;
  assign MemReq     = r_mem_req;
  assign MemWe      = r_mem_we;
  assign MemAddr    = r_mem_addr;
  assign MemBe      = r_mem_be;
  assign MemWdata   = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Directed transactions against mem_access_unit (32-bit data, TIMEOUT=4).
// A transaction-level model predicts the outcome of each request; a monitor
// compares the DUT against it every cycle; literal values pin the model.

module tb_mem_access_unit;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic        LoadSigned = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Misaligned;
  logic        BusError;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [3:0]  MemBe;
  logic [31:0] MemWdata;
  logic [31:0] MemRdata = '0;
  logic        MemReady = 1'b0;

  mem_access_unit #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Size      (Size),
    .LoadSigned(LoadSigned),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Misaligned(Misaligned),
    .BusError  (BusError),
    .MemReq    (MemReq),
    .MemWe     (MemWe),
    .MemAddr   (MemAddr),
    .MemBe     (MemBe),
    .MemWdata  (MemWdata),
    .MemRdata  (MemRdata),
    .MemReady  (MemReady)
  );

  initial forever #5 Clock = ~Clock;

  // k: MemReady arrives in the (k+1)-th cycle of MemReq; k<0 means never.
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          k;
    logic        spur;
  } req_t;

  typedef struct packed {
    logic        mis;
    logic        bus;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic        chk_rd;
    logic [31:0] rdata;
    int          req_cycles;
    int          stall_cycles;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        cur_exp;
  string       cur_name = "none";
  int          cur_k = -1;
  logic [31:0] cur_rdata = '0;
  logic        spurious = 1'b0;
  bit          active = 1'b0;
  bit          done = 1'b0;
  int          stall_cnt = 0;
  int          req_cnt = 0;
  int          req_n = 0;

  logic [31:0] snap_addr, snap_wdata, snap_rdata;
  logic [3:0]  snap_be;
  logic        snap_we, snap_mis, snap_bus;
  int          snap_stall, snap_req;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, expv);
    end
  endtask

  function automatic req_t mk(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                              input logic rd, input logic wr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int k, input logic spur);
    req_t r;
    r.addr = addr; r.size = size; r.sgn = sgn; r.rd = rd; r.wr = wr;
    r.wdata = wdata; r.rdata = rdata; r.k = k; r.spur = spur;
    return r;
  endfunction

  // Outcome of one request, from the access rules with plain arithmetic.
  function automatic exp_t model(input req_t r);
    exp_t        e;
    int          off;
    logic [31:0] lane;
    off = int'(r.addr % 32'd4);
    lane = '0;
    e.mis = 1'b0; e.bus = 1'b0; e.addr = r.addr - 32'(off); e.be = '0; e.wdata = '0;
    e.we = r.wr; e.chk_rd = 1'b0; e.rdata = '0; e.req_cycles = 0; e.stall_cycles = 1;
    if (r.rd && r.wr) begin
      e.bus = 1'b1;
      return e;
    end
    if (r.size == 2'b11 || (r.size == 2'b01 && off % 2 == 1) || (r.size == 2'b10 && off != 0)) begin
      e.mis = 1'b1;
      return e;
    end
    case (r.size)
      2'b00: begin
        e.be    = 4'(1 << off);
        e.wdata = (r.wdata & 32'hFF) << (8 * off);
        lane    = (r.rdata >> (8 * off)) & 32'hFF;
        if (r.sgn && lane >= 32'h80) lane = lane | 32'hFFFF_FF00;
      end
      2'b01: begin
        e.be    = 4'(3 << off);
        e.wdata = (r.wdata & 32'hFFFF) << (8 * off);
        lane    = (r.rdata >> (8 * off)) & 32'hFFFF;
        if (r.sgn && lane >= 32'h8000) lane = lane | 32'hFFFF_0000;
      end
      default: begin
        e.be    = 4'hF;
        e.wdata = r.wdata;
        lane    = r.rdata;
      end
    endcase
    e.chk_rd = 1'b1;
    if (r.k < 0 || r.k >= TIMEOUT) begin
      e.bus = 1'b1;
      e.rdata = '0;
      e.req_cycles = TIMEOUT;
      e.stall_cycles = TIMEOUT + 1;
    end else begin
      e.rdata = r.wr ? 32'h0 : lane;
      e.req_cycles = r.k + 1;
      e.stall_cycles = r.k + 2;
    end
    return e;
  endfunction

  task automatic arm(input string name, input req_t r);
    cur_name  = name;
    cur_exp   = model(r);
    cur_k     = r.k;
    cur_rdata = r.rdata;
    spurious  = r.spur;
    stall_cnt = 0;
    req_cnt   = 0;
    snap_addr = 'x; snap_be = 'x; snap_wdata = 'x; snap_we = 'x;
    done      = 1'b0;
    active    = 1'b1;
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clock);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check({name, ".completed"}, 32'(got), 32'd1);
    active = 1'b0;
  endtask

  task automatic do_txn(input string name, input req_t r);
    @(posedge Clock);
    #1;
    MemRead = r.rd; MemWrite = r.wr; Size = r.size; LoadSigned = r.sgn;
    Address = r.addr; WriteData = r.wdata;
    arm(name, r);
    wait_done(name);
    #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  // Wait-state memory: answers in the k-th cycle of MemReq, optionally
  // pulsing MemReady while no request is outstanding.
  initial begin
    forever begin
      @(negedge Clock);
      if (MemReq) begin
        MemReady = (req_n == cur_k);
        MemRdata = (req_n == cur_k) ? cur_rdata : $urandom;
        req_n++;
      end else begin
        MemReady = spurious;
        MemRdata = $urandom;
        req_n = 0;
      end
    end
  end

  // Compare the DUT with the model on every cycle of an armed transaction.
  initial begin
    forever begin
      @(negedge Clock);
      if (active) begin
        if (Stall) stall_cnt++;
        if (MemReq) begin
          req_cnt++;
          check($sformatf("%s.mem_addr", cur_name), MemAddr, cur_exp.addr);
          check($sformatf("%s.mem_be", cur_name), 32'(MemBe), 32'(cur_exp.be));
          check($sformatf("%s.mem_wdata", cur_name), MemWdata, cur_exp.wdata);
          check($sformatf("%s.mem_we", cur_name), 32'(MemWe), 32'(cur_exp.we));
          snap_addr = MemAddr; snap_be = MemBe; snap_wdata = MemWdata; snap_we = MemWe;
        end
        if (!Stall) begin
          check($sformatf("%s.misaligned", cur_name), 32'(Misaligned), 32'(cur_exp.mis));
          check($sformatf("%s.bus_error", cur_name), 32'(BusError), 32'(cur_exp.bus));
          if (cur_exp.chk_rd)
            check($sformatf("%s.read_data", cur_name), ReadData, cur_exp.rdata);
          check($sformatf("%s.req_cycles", cur_name), 32'(req_cnt), 32'(cur_exp.req_cycles));
          check($sformatf("%s.stall_cycles", cur_name), 32'(stall_cnt), 32'(cur_exp.stall_cycles));
          snap_rdata = ReadData; snap_mis = Misaligned; snap_bus = BusError;
          snap_stall = stall_cnt; snap_req = req_cnt;
          active = 1'b0;
          done = 1'b1;
        end
      end
    end
  end

  initial begin
    Resetn = 1'b0;
    repeat (3) @(posedge Clock);
    #1 Resetn = 1'b1;

    // Reset state
    @(negedge Clock);
    check("reset.mem_req", 32'(MemReq), 32'd0);
    check("reset.mem_we", 32'(MemWe), 32'd0);
    check("reset.mem_addr", MemAddr, 32'd0);
    check("reset.mem_be", 32'(MemBe), 32'd0);
    check("reset.mem_wdata", MemWdata, 32'd0);
    check("reset.read_data", ReadData, 32'd0);
    check("reset.misaligned", 32'(Misaligned), 32'd0);
    check("reset.bus_error", 32'(BusError), 32'd0);
    check("reset.stall", 32'(Stall), 32'd0);

    do_txn("word_read", mk(32'h10, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 3, 1'b0));
    check("word_read.lit_be", 32'(snap_be), 32'hF);
    check("word_read.lit_rdata", snap_rdata, 32'hDEADBEEF);
    check("word_read.lit_stall", 32'(snap_stall), 32'd5);

    do_txn("lb_signed", mk(32'h13, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0, 32'h80123456, 0, 1'b1));
    check("lb_signed.lit_be", 32'(snap_be), 32'h8);
    check("lb_signed.lit_rdata", snap_rdata, 32'hFFFFFF80);
    check("lb_signed.lit_stall", 32'(snap_stall), 32'd2);

    do_txn("lb_unsigned", mk(32'h13, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 32'h80123456, 2, 1'b0));
    check("lb_unsigned.lit_rdata", snap_rdata, 32'h00000080);

    do_txn("sh_store", mk(32'h6, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0000BEEF, 32'h5555AAAA, 1, 1'b0));
    check("sh_store.lit_addr", snap_addr, 32'h4);
    check("sh_store.lit_be", 32'(snap_be), 32'hC);
    check("sh_store.lit_wdata", snap_wdata, 32'hBEEF0000);
    check("sh_store.lit_we", 32'(snap_we), 32'd1);

    do_txn("lw_misaligned", mk(32'h2, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b1));
    check("lw_misaligned.lit_mis", 32'(snap_mis), 32'd1);
    check("lw_misaligned.lit_req", 32'(snap_req), 32'd0);
    check("lw_misaligned.lit_stall", 32'(snap_stall), 32'd1);

    do_txn("lh_misaligned", mk(32'h1, 2'b01, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0));
    check("lh_misaligned.lit_mis", 32'(snap_mis), 32'd1);

    do_txn("timeout", mk(32'h20, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 32'h12345678, -1, 1'b0));
    check("timeout.lit_req", 32'(snap_req), 32'd4);
    check("timeout.lit_bus", 32'(snap_bus), 32'd1);
    check("timeout.lit_rdata", snap_rdata, 32'h0);

    do_txn("conflict", mk(32'h30, 2'b10, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 0, 1'b0));
    check("conflict.lit_bus", 32'(snap_bus), 32'd1);
    check("conflict.lit_req", 32'(snap_req), 32'd0);

    do_txn("lh_signed_late", mk(32'h2, 2'b01, 1'b1, 1'b1, 1'b0, 32'h0, 32'h80011234, 3, 1'b1));
    check("lh_signed_late.lit_rdata", snap_rdata, 32'hFFFF8001);
    check("lh_signed_late.lit_bus", 32'(snap_bus), 32'd0);

    do_txn("sb_store", mk(32'h5, 2'b00, 1'b0, 1'b0, 1'b1, 32'h123456AB, 32'h0, 0, 1'b0));
    check("sb_store.lit_be", 32'(snap_be), 32'h2);
    check("sb_store.lit_wdata", snap_wdata, 32'h0000AB00);

    do_txn("illegal_size", mk(32'h8, 2'b11, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0));
    do_txn("lb_pos", mk(32'h21, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0, 32'h00007F00, 1, 1'b0));
    do_txn("sw_store", mk(32'h44, 2'b10, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 32'hFFFFFFFF, 2, 1'b1));
    do_txn("lhu", mk(32'h2, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0, 32'h80011234, 0, 1'b0));
    check("lhu.lit_rdata", snap_rdata, 32'h00008001);

    // Reset in the middle of BUSY, request held throughout.
    @(posedge Clock);
    #1;
    MemRead = 1'b1; MemWrite = 1'b0; Size = 2'b10; LoadSigned = 1'b0;
    Address = 32'h40; WriteData = '0;
    cur_k = -1;
    repeat (3) @(posedge Clock);
    #1 Resetn = 1'b0;
    @(posedge Clock);
    #1 Resetn = 1'b1;
    arm("restart", mk(32'h40, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 32'h01234567, 1, 1'b0));
    @(negedge Clock);
    check("mid_reset.mem_req", 32'(MemReq), 32'd0);
    check("mid_reset.misaligned", 32'(Misaligned), 32'd0);
    check("mid_reset.bus_error", 32'(BusError), 32'd0);
    check("mid_reset.mem_be", 32'(MemBe), 32'd0);
    check("mid_reset.stall", 32'(Stall), 32'd1);
    wait_done("restart");
    #1;
    MemRead = 1'b0;
    check("restart.lit_rdata", snap_rdata, 32'h01234567);
    check("restart.lit_stall", 32'(snap_stall), 32'd3);

    repeat (2) @(posedge Clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
